// File: rtl/rojobot_port_if.sv
// PicoBlaze port-bus responder for the Rojobot register block: motor-control write
// capture, coherent status snapshots for reads, and the update-interrupt handshake.
module rojobot_port_if #(
    parameter bit ALT_ENABLE = 1'b1
) (
    input  logic       sysclk,
    input  logic       sysreset_n,
    input  logic [7:0] port_id,
    input  logic [7:0] io_data_in,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] io_data_out,
    output logic       bot_sel,
    input  logic       interrupt_ack,
    output logic       interrupt_request,
    input  logic       upd_sysregs,
    input  logic [7:0] locx,
    input  logic [7:0] locy,
    input  logic [7:0] botinfo,
    input  logic [7:0] sensors,
    input  logic [7:0] lmdist,
    input  logic [7:0] rmdist,
    output logic [7:0] motctl,
    output logic       motctl_wr,
    output logic [7:0] ovr_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } irq_state_t;

    localparam logic [3:0] OFS_MOTCTL  = 4'h9;
    localparam logic [3:0] OFS_LOCX    = 4'hA;
    localparam logic [3:0] OFS_LOCY    = 4'hB;
    localparam logic [3:0] OFS_BOTINFO = 4'hC;
    localparam logic [3:0] OFS_SENSORS = 4'hD;
    localparam logic [3:0] OFS_LMDIST  = 4'hE;
    localparam logic [3:0] OFS_RMDIST  = 4'hF;

    irq_state_t state, state_next;
    logic [7:0] shadow [6];
    logic [7:0] rd_data;
    logic [3:0] offset;
    logic       overrun;

    // read_strobe carries no side effects; it is accepted only for bus completeness.
    logic unused_read_strobe;
    assign unused_read_strobe = read_strobe;

    assign offset  = port_id[3:0];
    assign bot_sel = (port_id[7:5] == 3'b000)
                   && (!port_id[4] || ALT_ENABLE)
                   && (offset >= OFS_MOTCTL);

    // NOTE: always_comb outputs get a default before any branch, so no path can infer a latch.
    always_comb begin
        rd_data = 8'h00;
        if (bot_sel) begin
            case (offset)
                OFS_MOTCTL:  rd_data = motctl;
                OFS_LOCX:    rd_data = shadow[0];
                OFS_LOCY:    rd_data = shadow[1];
                OFS_BOTINFO: rd_data = shadow[2];
                OFS_SENSORS: rd_data = shadow[3];
                OFS_LMDIST:  rd_data = shadow[4];
                OFS_RMDIST:  rd_data = shadow[5];
                default:     rd_data = 8'h00;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            io_data_out <= 8'h00;
            motctl      <= 8'h00;
            motctl_wr   <= 1'b0;
        end else begin
            // Read mux samples the pre-update shadow when a snapshot lands in the same cycle.
            io_data_out <= rd_data;
            motctl_wr   <= 1'b0;
            if (write_strobe && bot_sel && (offset == OFS_MOTCTL)) begin
                motctl    <= io_data_in;
                motctl_wr <= 1'b1;
            end
        end
    end

    // NOTE: the shadow array is reset explicitly; software may read it before the first update.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            for (int i = 0; i < 6; i++) shadow[i] <= 8'h00;
        end else if (upd_sysregs) begin
            shadow[0] <= locx;
            shadow[1] <= locy;
            shadow[2] <= botinfo;
            shadow[3] <= sensors;
            shadow[4] <= lmdist;
            shadow[5] <= rmdist;
        end
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) state <= IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (upd_sysregs) state_next = REQ;
            REQ:  if (interrupt_ack && !upd_sysregs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        interrupt_request = (state == REQ);
    end

    // An update arriving while the previous one is still unacknowledged is an overrun.
    assign overrun = (state == REQ) && upd_sysregs && !interrupt_ack;

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n)                      ovr_cnt <= 8'h00;
        else if (overrun && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
    end

endmodule

// File: doc/rojobot_port_if.md
# rojobot_port_if

PicoBlaze port-bus responder for the Rojobot register block. It decodes the motor-control and bot-status port addresses (0x09–0x0F, alias 0x19–0x1F). It captures motor-control writes from the PicoBlaze and returns coherent snapshots of the Rojobot status registers on reads. It sits between the PicoBlaze port bus and the Rojobot, and drives the system-register-update interrupt request with a request/acknowledge handshake.

## Interface
- ALT_ENABLE, 1 — when 1, port_id[4] is ignored in decode, so 0x19–0x1F alias 0x09–0x0F; when 0, only 0x09–0x0F decode.
- sysclk  in  1  100 MHz system clock; all state changes on the rising edge.
- sysreset_n  in  1  asynchronous, active-low reset.
- port_id  in  8  PicoBlaze port address.
- io_data_in  in  8  write data from the PicoBlaze (out_port).
- write_strobe  in  1  PicoBlaze write qualifier, one cycle.
- read_strobe  in  1  PicoBlaze read qualifier, one cycle.
- io_data_out  out  8  read data to the PicoBlaze in_port mux.
- bot_sel  out  1  combinational; high while port_id decodes to this block. The top level uses it to steer io_data_out onto in_port.
- interrupt_ack  in  1  PicoBlaze interrupt acknowledge, one cycle.
- interrupt_request  out  1  level interrupt request.
- upd_sysregs  in  1  Rojobot "registers updated" pulse, one cycle.
- locx, locy, botinfo, sensors, lmdist, rmdist  in  8 each  live Rojobot status registers.
- motctl  out  8  registered motor-control byte to the Rojobot.
- motctl_wr  out  1  one-cycle pulse on each accepted motctl write.
- ovr_cnt  out  8  saturating count of update-interrupt overruns.

## Operation
- **Decode.**
  - port_id[7:5] must be 000.
  - port_id[4] must be 0, or ALT_ENABLE must be 1.
  - port_id[3:0] must be in 9..F.
  - Offset map: 9 MOTCTL (R/W), A LOCX, B LOCY, C BOTINFO, D SENSORS, E LMDIST, F RMDIST (all read-only).
- **Snapshot.**
  - On a sampled upd_sysregs, the six status inputs load into shadow registers in the same edge.
  - Reads always return shadow values, never live inputs.
  - Shadow registers reset to 0x00.
- **Write.**
  - Condition: write_strobe=1 and decoded offset 9.
  - Effect: motctl <= io_data_in and motctl_wr=1 for exactly one cycle.
  - Writes to offsets A–F and undecoded addresses are ignored and do not pulse motctl_wr.
- **Read.**
  - Each edge: io_data_out <= selected shadow (offset A–F) or motctl (offset 9); 0x00 when not decoded.
  - This is independent of read_strobe; read_strobe has no side effects.
- **Interrupt FSM**, two states IDLE and REQ; interrupt_request = (state==REQ).
  - IDLE, upd_sysregs=1 -> REQ.
  - REQ, interrupt_ack=1 and upd_sysregs=0 -> IDLE.
  - REQ, interrupt_ack=1 and upd_sysregs=1 -> stay REQ (new request); ovr_cnt unchanged.
  - REQ, interrupt_ack=0 and upd_sysregs=1 -> stay REQ; snapshot still updates; ovr_cnt += 1, saturating at 0xFF.
  - IDLE, interrupt_ack=1 -> ignored.
- **Reset** (asynchronous, any time, including mid-request):
  - state=IDLE and interrupt_request=0.
  - motctl=0x00 and motctl_wr=0.
  - io_data_out=0x00 and ovr_cnt=0x00.
  - All shadows=0x00.
  - Release takes effect on the first edge with sysreset_n=1.

## Timing
- bot_sel is combinational from port_id, with zero latency.
- io_data_out is registered with 1-cycle latency from port_id. This meets the kcpsm6 2-cycle port_id-valid input window.
- A write is visible on motctl, with motctl_wr high, the cycle after the edge that samples write_strobe.
- interrupt_request rises the cycle after upd_sysregs is sampled. It falls the cycle after interrupt_ack is sampled.
- The shadow loaded by upd_sysregs at edge N is readable from edge N+1 onward.
- upd_sysregs and a decoded read in the same cycle: io_data_out gets the pre-update shadow value.

## Test plan
- **Reset values:** assert sysreset_n=0 mid-REQ with motctl=0x5A -> immediately interrupt_request=0, motctl=0x00, io_data_out=0x00, ovr_cnt=0x00.
- **Snapshot coherence:** locx=0x12, locy=0x34, upd_sysregs pulse, then change inputs to 0xFF -> reads at 0x0A/0x0B return 0x12/0x34; with ALT_ENABLE=1, 0x1A/0x1B return the same.
- **Motor-control write:** write 0xA5 to 0x09 -> motctl=0xA5 and motctl_wr high for one cycle; a read at 0x09 returns 0xA5.
  - Write 0x77 to 0x0C -> no change, no pulse.
  - With ALT_ENABLE=0, a write to 0x19 -> ignored.
- **Handshake:** upd_sysregs pulse -> interrupt_request high next cycle and held for 20 cycles; interrupt_ack -> low next cycle.
- **Overrun and simultaneous events:**
  - Three upd_sysregs pulses while REQ -> ovr_cnt=3.
  - upd_sysregs together with interrupt_ack -> stays REQ and ovr_cnt stays 3.
  - 300 overruns -> ovr_cnt=0xFF.
- **Undecoded address:** port_id=0x20 or 0x08 -> bot_sel=0 and io_data_out=0x00 next cycle.
